// File: rtl/r88_alu_seq_pkg.sv
// Shared types and helpers for the r88 sequential ALU.
package r88_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [2:0] {
    R88_ALU_SHL = 3'd0,
    R88_ALU_SHR = 3'd1,
    R88_ALU_CMP = 3'd2,
    R88_ALU_ADD = 3'd3,
    R88_ALU_SUB = 3'd4,
    R88_ALU_OR  = 3'd5,
    R88_ALU_AND = 3'd6,
    R88_ALU_XOR = 3'd7
  } aluOp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } aluState_e;

  // Carry seen by the arithmetic: cmp always 1, sub defaults to 1 (no borrow), others to 0.
  function automatic logic effCarry(aluOp_e op, logic cin, logic cinEn);
    if (op == R88_ALU_CMP) return 1'b1;
    if (cinEn) return cin;
    return (op == R88_ALU_SUB);
  endfunction

endpackage

// File: rtl/r88_alu_seq_if.sv
// Request/result handshake bundle between sequencer and ALU.
interface r88_alu_seq_if #(parameter int WIDTH = 8);
  logic             startValid;
  logic             startReady;
  logic [2:0]       aluOp;
  logic [WIDTH-1:0] opLeft;
  logic [WIDTH-1:0] opRight;
  logic             carryIn;
  logic             carryInEn;
  logic             decMode;
  logic             invOut;
  logic             resValid;
  logic             resReady;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             zeroOut;
  logic             negOut;
  logic             ovfOut;

  modport master (
    output startValid, aluOp, opLeft, opRight, carryIn, carryInEn, decMode, invOut, resReady,
    input  startReady, resValid, result, carryOut, zeroOut, negOut, ovfOut
  );

  modport slave (
    input  startValid, aluOp, opLeft, opRight, carryIn, carryInEn, decMode, invOut, resReady,
    output startReady, resValid, result, carryOut, zeroOut, negOut, ovfOut
  );
endinterface

// File: rtl/r88_alu_seq_bcd_nibble.sv
// One BCD digit of add/subtract; carry is borrow-not when subtracting.
module r88_bcd_nibble (
  input  logic [3:0] l,
  input  logic [3:0] r,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);
  logic [5:0] s;

  always_comb begin
    s    = '0;
    cout = 1'b0;
    if (sub) begin
      // Signed 6-bit difference; bit 5 flags a borrow.
      s = {2'b00, l} - {2'b00, r} - {5'b00000, ~cin};
      if (s[5]) begin
        s    = s + 6'd10;
        cout = 1'b0;
      end else begin
        cout = 1'b1;
      end
    end else begin
      s = {2'b00, l} + {2'b00, r} + {5'b00000, cin};
      if (s > 6'd9) begin
        s    = s + 6'd6;
        cout = 1'b1;
      end
    end
    digit = s[3:0];
  end
endmodule

// File: rtl/r88_alu_seq.sv
// Registered ALU with flag set; decimal cmp/add/sub run nibble-serially, one digit per cycle.
module r88_alu_seq
  import r88_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         sysClock,
  input  logic         sysResetN,
  r88_alu_seq_if.slave bus
);
  localparam int NUM_NIB = WIDTH / NIBBLE;
  localparam int CW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  aluState_e        state, stateNext;
  aluOp_e           opReg;
  logic [WIDTH-1:0] lReg, rReg, accReg, resultReg;
  logic             cinReg, cinEnReg, decReg, invReg;
  logic             nibCarry;
  logic [CW-1:0]    nibIdx;
  logic             cReg, zReg, nReg, vReg;

  logic             isDec, lastNib, cinEff;
  logic [WIDTH:0]   sumAdd, sumSub;
  logic [WIDTH-1:0] binRes, binFlagVal, lRot, decAcc, decRes;
  logic             binC, binV;
  logic [3:0]       nibDigit;
  logic             nibCout;

  assign isDec   = decReg && (opReg inside {R88_ALU_CMP, R88_ALU_ADD, R88_ALU_SUB});
  assign lastNib = (nibIdx == CW'(NUM_NIB - 1));
  assign cinEff  = effCarry(opReg, cinReg, cinEnReg);

  r88_bcd_nibble uNibble (
    .l    (lReg[NIBBLE-1:0]),
    .r    (rReg[NIBBLE-1:0]),
    .cin  (nibCarry),
    .sub  (opReg != R88_ALU_ADD),
    .digit(nibDigit),
    .cout (nibCout)
  );

  // L rotates through the nibble slot so it is whole again after the last digit (needed by cmp).
  assign lRot   = (lReg >> NIBBLE) | (lReg << (WIDTH - NIBBLE));
  assign decAcc = (accReg >> NIBBLE) | (WIDTH'(nibDigit) << (WIDTH - NIBBLE));
  assign decRes = (opReg == R88_ALU_CMP) ? lRot : decAcc;

  always_comb begin
    sumAdd     = {1'b0, lReg} + {1'b0, rReg} + {{WIDTH{1'b0}}, cinEff};
    sumSub     = {1'b0, lReg} + {1'b0, ~rReg} + {{WIDTH{1'b0}}, cinEff};
    binRes     = '0;
    binFlagVal = '0;
    binC       = 1'b0;
    binV       = 1'b0;
    case (opReg)
      R88_ALU_SHL: begin
        binRes = {rReg[WIDTH-2:0], cinEff};
        binC   = rReg[WIDTH-1];
      end
      R88_ALU_SHR: begin
        binRes = {cinEff, rReg[WIDTH-1:1]};
        binC   = rReg[0];
      end
      R88_ALU_CMP: begin
        binRes     = lReg;
        binFlagVal = sumSub[WIDTH-1:0];
        binC       = sumSub[WIDTH];
        binV       = (lReg[WIDTH-1] != rReg[WIDTH-1]) && (sumSub[WIDTH-1] != lReg[WIDTH-1]);
      end
      R88_ALU_ADD: begin
        binRes = sumAdd[WIDTH-1:0];
        binC   = sumAdd[WIDTH];
        binV   = (lReg[WIDTH-1] == rReg[WIDTH-1]) && (sumAdd[WIDTH-1] != lReg[WIDTH-1]);
      end
      R88_ALU_SUB: begin
        binRes = sumSub[WIDTH-1:0];
        binC   = sumSub[WIDTH];
        binV   = (lReg[WIDTH-1] != rReg[WIDTH-1]) && (sumSub[WIDTH-1] != lReg[WIDTH-1]);
      end
      R88_ALU_OR:  binRes = lReg | rReg;
      R88_ALU_AND: binRes = lReg & rReg;
      R88_ALU_XOR: binRes = lReg ^ rReg;
      default:     binRes = '0;
    endcase
    if (opReg != R88_ALU_CMP) binFlagVal = binRes;
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) state <= ST_IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (bus.startValid) stateNext = ST_BUSY;
      ST_BUSY: if (!isDec || lastNib) stateNext = ST_DONE;
      ST_DONE: if (bus.resReady) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      opReg     <= R88_ALU_SHL;
      lReg      <= '0;
      rReg      <= '0;
      accReg    <= '0;
      resultReg <= '0;
      cinReg    <= 1'b0;
      cinEnReg  <= 1'b0;
      decReg    <= 1'b0;
      invReg    <= 1'b0;
      nibCarry  <= 1'b0;
      nibIdx    <= '0;
      cReg      <= 1'b0;
      zReg      <= 1'b0;
      nReg      <= 1'b0;
      vReg      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.startValid) begin
          opReg    <= aluOp_e'(bus.aluOp);
          lReg     <= bus.opLeft;
          rReg     <= bus.opRight;
          cinReg   <= bus.carryIn;
          cinEnReg <= bus.carryInEn;
          decReg   <= bus.decMode;
          invReg   <= bus.invOut;
          nibCarry <= effCarry(aluOp_e'(bus.aluOp), bus.carryIn, bus.carryInEn);
          nibIdx   <= '0;
          accReg   <= '0;
        end
        ST_BUSY: begin
          if (isDec) begin
            lReg     <= lRot;
            rReg     <= rReg >> NIBBLE;
            accReg   <= decAcc;
            nibCarry <= nibCout;
            nibIdx   <= nibIdx + 1'b1;
            if (lastNib) begin
              resultReg <= decRes ^ {WIDTH{invReg}};
              cReg      <= nibCout;
              zReg      <= (decAcc == '0);
              nReg      <= decAcc[WIDTH-1];
              vReg      <= 1'b0;
            end
          end else begin
            resultReg <= binRes ^ {WIDTH{invReg}};
            cReg      <= binC;
            zReg      <= (binFlagVal == '0);
            nReg      <= binFlagVal[WIDTH-1];
            vReg      <= binV;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.startReady = (state == ST_IDLE);
  assign bus.resValid   = (state == ST_DONE);
  assign bus.result     = resultReg;
  assign bus.carryOut   = cReg;
  assign bus.zeroOut    = zReg;
  assign bus.negOut     = nReg;
  assign bus.ovfOut     = vReg;
endmodule

// File: tb/tb_r88_alu_seq.sv
// Directed bench for r88_alu_seq: 8-bit and 16-bit instances, hand-computed vectors.
module tb_r88_alu_seq;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;
  int   lat;

  always #5 clk = ~clk;

  r88_alu_seq_if #(.WIDTH(8))  bus8();
  r88_alu_seq_if #(.WIDTH(16)) bus16();

  r88_alu_seq #(.WIDTH(8))  dut8  (.sysClock(clk), .sysResetN(rstN), .bus(bus8));
  r88_alu_seq #(.WIDTH(16)) dut16 (.sysClock(clk), .sysResetN(rstN), .bus(bus16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags8(input string tag, input logic [7:0] res, input logic c, z, n, v);
    check({tag, "_res"}, {24'h0, bus8.result}, {24'h0, res});
    check({tag, "_flags"}, {28'h0, bus8.carryOut, bus8.zeroOut, bus8.negOut, bus8.ovfOut},
          {28'h0, c, z, n, v});
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] l, r,
                      input logic cin, en, dec, inv, output int latency);
    bus8.aluOp = op; bus8.opLeft = l; bus8.opRight = r;
    bus8.carryIn = cin; bus8.carryInEn = en; bus8.decMode = dec; bus8.invOut = inv;
    bus8.startValid = 1'b1;
    @(posedge clk); #1;
    bus8.startValid = 1'b0;
    latency = 0;
    while (!bus8.resValid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic consume8;
    bus8.resReady = 1'b1;
    @(posedge clk); #1;
    bus8.resReady = 1'b0;
    check("consume_ready", {31'h0, bus8.startReady}, 32'h1);
  endtask

  initial begin
    bus8.startValid = 0; bus8.resReady = 0; bus8.aluOp = 0; bus8.opLeft = 0; bus8.opRight = 0;
    bus8.carryIn = 0; bus8.carryInEn = 0; bus8.decMode = 0; bus8.invOut = 0;
    bus16.startValid = 0; bus16.resReady = 0; bus16.aluOp = 0; bus16.opLeft = 0; bus16.opRight = 0;
    bus16.carryIn = 0; bus16.carryInEn = 0; bus16.decMode = 0; bus16.invOut = 0;

    #12;
    check("rst_ready", {31'h0, bus8.startReady}, 32'h1);
    check("rst_valid", {31'h0, bus8.resValid}, 32'h0);
    flags8("rst", 8'h00, 0, 0, 0, 0);
    #10 rstN = 1'b1;
    @(posedge clk); #1;

    // binary add with signed overflow
    run8(3'd3, 8'h7F, 8'h01, 0, 0, 0, 0, lat);
    check("add_lat", lat, 1);
    flags8("add", 8'h80, 0, 0, 1, 1);
    consume8();
    check("consume_valid", {31'h0, bus8.resValid}, 32'h0);

    run8(3'd3, 8'h58, 8'h46, 1, 1, 1, 0, lat);
    check("dadd_lat", lat, 2);
    flags8("dadd", 8'h05, 1, 0, 0, 0);
    consume8();

    run8(3'd4, 8'h10, 8'h01, 0, 0, 1, 0, lat);
    check("dsub_lat", lat, 2);
    flags8("dsub", 8'h09, 1, 0, 0, 0);
    consume8();

    run8(3'd2, 8'h20, 8'h30, 0, 0, 0, 0, lat);
    check("cmp_lat", lat, 1);
    flags8("cmp", 8'h20, 0, 0, 1, 0);
    consume8();

    run8(3'd1, 8'h00, 8'h81, 1, 1, 0, 1, lat);
    flags8("shr_inv", 8'h3F, 1, 0, 1, 0);
    consume8();

    run8(3'd0, 8'h00, 8'h80, 1, 0, 0, 0, lat);
    flags8("shl", 8'h00, 1, 1, 0, 0);
    consume8();

    run8(3'd4, 8'h00, 8'h01, 0, 0, 0, 0, lat);
    flags8("sub_borrow", 8'hFF, 0, 0, 1, 0);
    consume8();

    run8(3'd4, 8'h80, 8'h01, 0, 0, 0, 0, lat);
    flags8("sub_ovf", 8'h7F, 1, 0, 0, 1);
    consume8();

    // decMode is ignored by logic ops
    run8(3'd7, 8'hF0, 8'hFF, 1, 1, 1, 0, lat);
    check("xor_lat", lat, 1);
    flags8("xor", 8'h0F, 0, 0, 0, 0);
    consume8();

    run8(3'd2, 8'h25, 8'h25, 0, 0, 1, 0, lat);
    check("dcmp_lat", lat, 2);
    flags8("dcmp", 8'h25, 1, 1, 0, 0);
    consume8();

    // 16-bit decimal add, latency 4
    bus16.aluOp = 3'd3; bus16.opLeft = 16'h9999; bus16.opRight = 16'h0001;
    bus16.carryIn = 0; bus16.carryInEn = 0; bus16.decMode = 1; bus16.invOut = 0;
    bus16.startValid = 1'b1;
    @(posedge clk); #1;
    bus16.startValid = 1'b0;
    lat = 0;
    while (!bus16.resValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("d16_lat", lat, 4);
    check("d16_res", {16'h0, bus16.result}, 32'h0);
    check("d16_flags", {28'h0, bus16.carryOut, bus16.zeroOut, bus16.negOut, bus16.ovfOut}, 32'h4 | 32'h8);
    bus16.resReady = 1'b1;
    @(posedge clk); #1;
    bus16.resReady = 1'b0;
    check("d16_ready", {31'h0, bus16.startReady}, 32'h1);

    // backpressure: DONE holds while a competing request is ignored
    run8(3'd6, 8'hF0, 8'h3C, 0, 0, 0, 0, lat);
    bus8.aluOp = 3'd5; bus8.opLeft = 8'h01; bus8.opRight = 8'h02; bus8.startValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      flags8("bp_hold", 8'h30, 0, 0, 0, 0);
      check("bp_ready", {31'h0, bus8.startReady}, 32'h0);
      check("bp_valid", {31'h0, bus8.resValid}, 32'h1);
    end
    bus8.startValid = 1'b0;
    consume8();
    check("bp_res_after", {24'h0, bus8.result}, 32'h30);

    // reset in the middle of a decimal BUSY
    run8(3'd3, 8'h00, 8'h00, 0, 0, 0, 0, lat);
    consume8();
    bus8.aluOp = 3'd3; bus8.opLeft = 8'h99; bus8.opRight = 8'h11; bus8.decMode = 1'b1;
    bus8.carryInEn = 1'b0; bus8.invOut = 1'b0; bus8.startValid = 1'b1;
    @(posedge clk); #1;
    bus8.startValid = 1'b0;
    check("pre_rst_busy", {31'h0, bus8.startReady}, 32'h0);
    #2 rstN = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, bus8.startReady}, 32'h1);
    check("mid_rst_valid", {31'h0, bus8.resValid}, 32'h0);
    flags8("mid_rst", 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("mid_rst_held", {31'h0, bus8.resValid}, 32'h0);
    #2 rstN = 1'b1;
    @(posedge clk); #1;
    run8(3'd3, 8'h01, 8'h01, 0, 0, 0, 0, lat);
    check("post_rst_lat", lat, 1);
    flags8("post_rst", 8'h02, 0, 0, 0, 0);
    consume8();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
